// File: rtl/fetch_redirect_unit.sv
// IF-stage PC sequencer: redirect target selection, imem req/ack fetch and the IF/ID register.
// Optional FETCH_PERF_CNT_EN adds a saturating redirect_count output.
module fetch_redirect_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_src,
    input  logic        is_j,
    input  logic        if_flush,
    input  logic [15:0] branch_imm,
    input  logic [25:0] jump_index,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0] redirect_count
`endif
);

    typedef enum logic [1:0] {BOOT, FETCH, HOLD, DROP} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] redir_pc_q, redir_pc_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;

    logic        redirect;
    logic [31:0] target;
    logic        fill;
    logic [31:0] fill_word;

    // A stalled branch re-resolves next cycle, so stall masks the redirect.
    assign redirect = !stall && valid_q && (is_j || pc_src);
    assign target   = is_j ? {pc4_q[31:28], jump_index, 2'b00}
                           : pc4_q + {{14{branch_imm[15]}}, branch_imm, 2'b00};

    assign imem_addr   = pc_q;
    assign if_id_instr = instr_q;
    assign if_id_pc4   = pc4_q;
    assign if_id_valid = valid_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        redir_pc_d = redir_pc_q;
        buf_d      = buf_q;
        fill       = 1'b0;
        fill_word  = imem_rdata;
        imem_req   = 1'b0;
        case (state_q)
            BOOT: state_d = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                if (redirect && imem_ack) begin
                    pc_d = target;
                end else if (redirect) begin
                    // Keep pc so the outstanding request address stays stable.
                    redir_pc_d = target;
                    state_d    = DROP;
                end else if (imem_ack && !stall) begin
                    fill = 1'b1;
                    pc_d = pc_q + 32'd4;
                end else if (imem_ack) begin
                    buf_d   = imem_rdata;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (stall) begin
                    state_d = HOLD;
                end else if (redirect) begin
                    pc_d    = target;
                    state_d = FETCH;
                end else begin
                    fill      = 1'b1;
                    fill_word = buf_q;
                    pc_d      = pc_q + 32'd4;
                    state_d   = FETCH;
                end
            end
            DROP: begin
                imem_req = 1'b1;
                if (redirect) redir_pc_d = target;
                if (imem_ack) begin
                    pc_d    = redirect ? target : redir_pc_q;
                    state_d = FETCH;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (!stall) begin
            if (fill) begin
                instr_d = fill_word;
                pc4_d   = pc_q + 32'd4;
                valid_d = 1'b1;
            end else begin
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            redir_pc_q <= 32'h0;
            buf_q      <= 32'h0;
            instr_q    <= NOP_INSTR;
            pc4_q      <= 32'h0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            redir_pc_q <= redir_pc_d;
            buf_q      <= buf_d;
            instr_q    <= instr_d;
            pc4_q      <= pc4_d;
            valid_q    <= valid_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] redirect_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_cnt_q <= 16'h0;
        end else if (redirect && redirect_cnt_q != 16'hFFFF) begin
            redirect_cnt_q <= redirect_cnt_q + 16'd1;
        end
    end

    assign redirect_count = redirect_cnt_q;
`endif

    a_redirect_flush: assert property (@(posedge clk) disable iff (rst)
        redirect |-> if_flush);

    a_addr_stable: assert property (@(posedge clk) disable iff (rst)
        (imem_req && !imem_ack) |=> $stable(imem_addr));

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Directed bench for fetch_redirect_unit: stimulus pushes expected fetch addresses and
// IF/ID entries into queues; an independent monitor pops and compares them.
module tb_fetch_redirect_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_src, is_j, if_flush, stall;
    logic [15:0] branch_imm;
    logic [25:0] jump_index;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] if_id_instr, if_id_pc4;
    logic        if_id_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] redirect_count;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] exp_addr_q[$];
    logic [63:0] exp_ifid_q[$];

    fetch_redirect_unit #(
        .RESET_PC (32'h0000_0040),
        .NOP_INSTR(32'h0000_0000)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .pc_src     (pc_src),
        .is_j       (is_j),
        .if_flush   (if_flush),
        .branch_imm (branch_imm),
        .jump_index (jump_index),
        .stall      (stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .if_id_instr(if_id_instr),
        .if_id_pc4  (if_id_pc4),
        .if_id_valid(if_id_valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .redirect_count(redirect_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] wd(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    // Instruction memory: word content is a fixed scramble of its address.
    assign imem_rdata = imem_ack ? wd(imem_addr) : 32'hDEAD_BEEF;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic with_ifid);
        exp_addr_q.push_back(a);
        if (with_ifid) exp_ifid_q.push_back({wd(a), a + 32'd4});
    endtask

    // Drive one cycle of inputs (just after a rising edge) and advance to the next.
    task automatic cyc(input logic a, input logic s, input logic ps, input logic j,
                       input logic [15:0] imm, input logic [25:0] idx);
        imem_ack   = a;
        stall      = s;
        pc_src     = ps;
        is_j       = j;
        if_flush   = ps | j;
        branch_imm = imm;
        jump_index = idx;
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares accepted requests and every freshly loaded IF/ID entry.
    logic        mon_stall, mon_rst, last_v;
    logic [63:0] last_e, e;
    logic [31:0] ea;
    initial begin
        last_v = 1'b0;
        last_e = 64'h0;
        forever begin
            @(posedge clk);
            mon_stall = stall;
            mon_rst   = rst;
            @(negedge clk);
            if (mon_rst) begin
                last_v = 1'b0;
                continue;
            end
            if (imem_req && imem_ack) begin
                if (exp_addr_q.size() == 0) begin
                    chk("unexpected_req", {32'h0, imem_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    ea = exp_addr_q.pop_front();
                    chk("req_addr", {32'h0, imem_addr}, {32'h0, ea});
                end
            end
            if (mon_stall) begin
                chk("ifid_hold_valid", {63'h0, if_id_valid}, {63'h0, last_v});
                if (last_v) chk("ifid_hold", {if_id_instr, if_id_pc4}, last_e);
            end else if (if_id_valid) begin
                if (exp_ifid_q.size() == 0) begin
                    chk("unexpected_ifid", {if_id_instr, if_id_pc4}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = exp_ifid_q.pop_front();
                    chk("ifid", {if_id_instr, if_id_pc4}, e);
                    last_e = e;
                end
                last_v = 1'b1;
            end else begin
                last_v = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        imem_ack = 1'b0; stall = 1'b0; pc_src = 1'b0; is_j = 1'b0; if_flush = 1'b0;
        branch_imm = 16'h0; jump_index = 26'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req",   {63'h0, imem_req},    64'h0);
        chk("rst_valid", {63'h0, if_id_valid}, 64'h0);
        chk("rst_instr", {32'h0, if_id_instr}, 64'h0);
        chk("rst_pc4",   {32'h0, if_id_pc4},   64'h0);
        chk("rst_addr",  {32'h0, imem_addr},   64'h40);
        rst = 1'b0;
        cyc(0, 0, 0, 0, 16'h0, 26'h0);                       // BOOT -> FETCH

        // Back-to-back stream 0x40 .. 0xFC, one word per cycle.
        chk("first_req", {63'h0, imem_req}, 64'h1);
        for (int k = 0; k < 48; k++) begin
            push(32'h40 + 32'(4 * k), 1'b1);
            cyc(1, 0, 0, 0, 16'h0, 26'h0);
        end

        // Branch from pc4 0x100, offset -2 words: fetched 0x100 is dropped.
        push(32'h100, 1'b0);
        cyc(1, 0, 1, 0, 16'hFFFE, 26'h0);
        push(32'hF8, 1'b1);
        cyc(1, 0, 0, 0, 16'h0, 26'h0);

        // Jump to 0x200 while the request at 0xFC waits three cycles for ack.
        chk("wait_addr0", {31'h0, imem_req, imem_addr}, {31'h0, 1'b1, 32'hFC});
        cyc(0, 0, 0, 1, 16'h0, 26'h80);
        chk("wait_addr1", {31'h0, imem_req, imem_addr}, {31'h0, 1'b1, 32'hFC});
        cyc(0, 0, 0, 0, 16'h0, 26'h0);
        chk("wait_addr2", {31'h0, imem_req, imem_addr}, {31'h0, 1'b1, 32'hFC});
        cyc(0, 0, 0, 0, 16'h0, 26'h0);
        push(32'hFC, 1'b0);
        cyc(1, 0, 0, 0, 16'h0, 26'h0);
        push(32'h200, 1'b1);
        cyc(1, 0, 0, 0, 16'h0, 26'h0);

        // Backward branch wrapping below zero: 0x204 - 0x214 = 0xFFFF_FFF0.
        push(32'h204, 1'b0);
        cyc(1, 0, 1, 0, 16'hFF7B, 26'h0);
        push(32'hFFFF_FFF0, 1'b1);
        cyc(1, 0, 0, 0, 16'h0, 26'h0);

        // Jump with pc_src also set: jump wins, keeps pc4[31:28]=0xF.
        push(32'hFFFF_FFF4, 1'b0);
        cyc(1, 0, 1, 1, 16'h0001, 26'h040);
        push(32'hF000_0100, 1'b1);
        cyc(1, 0, 0, 0, 16'h0, 26'h0);

        // Ack under stall -> HOLD for two stalled edges; stalled jump ignored.
        push(32'hF000_0104, 1'b0);
        cyc(1, 1, 0, 0, 16'h0, 26'h0);
        chk("hold_req0", {63'h0, imem_req}, 64'h0);
        cyc(0, 1, 0, 1, 16'h0, 26'h0);
        chk("hold_req1", {63'h0, imem_req}, 64'h0);
        exp_ifid_q.push_back({wd(32'hF000_0104), 32'hF000_0108});
        cyc(0, 0, 0, 0, 16'h0, 26'h0);
        push(32'hF000_0108, 1'b1);
        cyc(1, 0, 0, 0, 16'h0, 26'h0);

        // Redirect into DROP, then reset; ack during BOOT must be ignored.
        cyc(0, 0, 0, 1, 16'h0, 26'h100);
        chk("drop_addr", {31'h0, imem_req, imem_addr}, {31'h0, 1'b1, 32'hF000_010C});
        rst = 1'b1;
        cyc(0, 0, 0, 0, 16'h0, 26'h0);
        rst = 1'b0;
        chk("boot_req",   {63'h0, imem_req},    64'h0);
        chk("boot_valid", {63'h0, if_id_valid}, 64'h0);
        chk("boot_addr",  {32'h0, imem_addr},   64'h40);
        cyc(1, 0, 0, 0, 16'h0, 26'h0);
        chk("post_rst_addr", {31'h0, imem_req, imem_addr}, {31'h0, 1'b1, 32'h40});
        chk("post_rst_valid", {63'h0, if_id_valid}, 64'h0);
        push(32'h40, 1'b1);
        cyc(1, 0, 0, 0, 16'h0, 26'h0);
        push(32'h44, 1'b1);
        cyc(1, 0, 0, 0, 16'h0, 26'h0);
        repeat (3) cyc(0, 0, 0, 0, 16'h0, 26'h0);

        chk("addr_q_drained", 64'(exp_addr_q.size()), 64'h0);
        chk("ifid_q_drained", 64'(exp_ifid_q.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
